sram_1r1w_clear_arb: RTL and testbench
======================================

# sram_1r1w_clear_arb

Front-end controller for one `sram_1r1w_*` macro instance. The macros have no reset, so after reset, and on a flush request, the block clears every entry to `INIT_VALUE` by sweeping addresses. It then shares the single write port between two requesters with round-robin arbitration. It also gives the read port guaranteed NEW_DATA behaviour through a same-cycle write bypass. It sits between cache/tag control logic and the SRAM wrapper.

## Interface
- `DATA_WIDTH`, 20, entry width in bits
- `SIZE`, 64, number of entries; any value ≥2, need not be a power of two
- `INIT_VALUE`, 0, value written to every entry during clear
- `ADDR_WIDTH`, `$clog2(SIZE)`, derived; do not override

Ports:
- `clk` in 1 — single clock
- `reset` in 1 — synchronous, active-high
- `flush_en` in 1 — request a full clear; sampled only in RUN
- `init_done` out 1 — high in RUN, low while clearing
- `wa_valid`, `wa_addr[ADDR_WIDTH]`, `wa_data[DATA_WIDTH]` in — write requester A
- `wa_ready` out 1 — A's write accepted this cycle
- `wb_valid`, `wb_addr`, `wb_data` in; `wb_ready` out — write requester B, same meaning as A
- `rd_en` in 1, `rd_addr` in ADDR_WIDTH — read request
- `rd_data` out DATA_WIDTH — read result, one cycle after `rd_en`
- `mem_write_en`, `mem_write_addr`, `mem_write_data` out — to macro write port
- `mem_read_en`, `mem_read_addr` out — to macro read port
- `mem_read_data` in DATA_WIDTH — macro read result, one cycle after `mem_read_en`

## Operation
- States: CLEAR, RUN.
- `reset` high: state←CLEAR, clear counter←0, round-robin pointer←A, bypass flag←0.
- CLEAR:
  - `mem_write_en`=1 (forced 0 while `reset` high), `mem_write_addr`=counter, `mem_write_data`=`INIT_VALUE`.
  - Counter increments each cycle.
  - When counter==SIZE−1: write that entry, go to RUN, counter←0. Never write an address ≥SIZE.
  - `wa_ready`=`wb_ready`=0 and `init_done`=0.
  - `flush_en` is ignored.
- RUN:
  - `init_done`=1.
  - `flush_en`=1 → CLEAR next cycle. Any write granted in that same cycle still completes.
- Write arbitration (RUN only; `rr_arbiter`, 2 requesters):
  - Only one valid: it is granted.
  - Both valid: the requester not granted last time wins.
  - Pointer updates only on a grant.
  - Ready is combinational and means the write is accepted. Requesters hold valid, addr and data until ready.
- Read path:
  - `mem_read_en`=`rd_en`, `mem_read_addr`=`rd_addr`, in any state.
  - Bypass: a read and a granted write (or a clear write) to the same address in the same cycle → next-cycle `rd_data` = that write data.
  - Read issued in CLEAR → next-cycle `rd_data`=`INIT_VALUE`.
  - Otherwise `rd_data`=`mem_read_data`.
  - Bypass flag and data are registered; `rd_data` is a mux on them.
  - `rd_data` holds its last value when no read was issued (muxed value is don't-care; bench checks only after `rd_en`).

## Timing
- Clear duration is exactly SIZE cycles after `reset` falls. `init_done` rises in cycle SIZE; cycle 0 is the first cycle with `reset` low.
- Flush accepted at cycle t → clear writes in cycles t+1..t+SIZE; `init_done`=1 again at t+SIZE+1.
- Write grant: 0 cycles from valid (combinational). The macro write commits at the clock edge.
- Read latency is 1 cycle, fixed, including the bypass case.
- Reset mid-clear restarts the sweep at address 0.
- Reset outputs: `init_done`=0, `wa_ready`=`wb_ready`=0, `mem_write_en`=0. `rd_data` is undefined until the first read.

## Structure
- Shared package: `clear_state_t` enum {CLEAR, RUN}.
- Sub-module `rr_arbiter` (`NUM_REQUESTERS`=2): request vector in, one-hot grant out, `update_lru` input driven on grant.
- Everything else stays in one module: counter, FSM, bypass registers.

## Test plan
All scenarios use SIZE=52, DATA_WIDTH=20.
- Reset for 3 cycles, then idle → exactly 52 writes of 0 to addresses 0..51 in order, no address 52+. `init_done` rises in cycle 52.
- After init, write A addr 5 = 0x12345, then read addr 5 → `rd_data`=0x12345 one cycle after `rd_en`. Read addr 6 → 0.
- `wa_valid` and `wb_valid` held high for 4 cycles → grants alternate A,B,A,B. With B alone valid → B granted every cycle.
- Write addr 9 = 0xABCDE and read addr 9 in the same cycle (macro model returns stale data) → `rd_data`=0xABCDE next cycle.
- Write addr 3 = 0x77777, pulse `flush_en`, read addr 3 during the clear → `INIT_VALUE`; after `init_done` rises, read addr 3 → 0.
- Assert `reset` at clear count 20 → sweep restarts at address 0 and takes 52 more cycles. `wa_ready` stays 0 throughout.

Source files
------------

// File: rtl/sram_1r1w_clear_arb_pkg.sv
// Shared types for the SRAM clear/arbitration front end.
// Holds the clear FSM state encoding.
package sram_1r1w_clear_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clear_state_t;

endpackage

// File: rtl/sram_1r1w_clear_arb_rr.sv
// Round-robin arbiter: req in, one-hot grant out.
// Ports: clk, reset, req, update_lru, grant.
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  localparam int IW = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant
);

  logic [IW-1:0] last;
  logic [IW-1:0] gidx;
  int            idx;
  logic          found;

  // Search starts just after the last winner.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      idx = (int'(last) + i) % NUM_REQUESTERS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = IW'(idx);
        found      = 1'b1;
      end
    end
  end

  // Reset points "last" at the top index so
  // requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= IW'(NUM_REQUESTERS - 1);
    end else if (update_lru && found) begin
      last <= gidx;
    end
  end

endmodule

// File: rtl/sram_1r1w_clear_arb.sv
// SRAM front end: clear sweep, 2-way write arb,
// NEW_DATA read bypass. Ports: see port list.
module sram_1r1w_clear_arb
  import sram_1r1w_clear_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int SIZE       = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_en,
  output logic                  init_done,
  input  logic                  wa_valid,
  input  logic [ADDR_WIDTH-1:0] wa_addr,
  input  logic [DATA_WIDTH-1:0] wa_data,
  output logic                  wa_ready,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(SIZE - 1);

  clear_state_t          state;
  clear_state_t          state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  clearing;
  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  byp;
  logic [DATA_WIDTH-1:0] byp_data;

  assign clearing  = (state == CLEAR);
  assign init_done = (state == RUN);

  assign req = {wb_valid, wa_valid}
             & {2{init_done && !reset}};

  rr_arbiter #(
    .NUM_REQUESTERS(2)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .update_lru(|grant),
    .grant     (grant)
  );

  assign wa_ready = grant[0];
  assign wb_ready = grant[1];

  always_comb begin
    mem_write_en   = 1'b0;
    mem_write_addr = cnt;
    mem_write_data = INIT_VALUE;
    if (clearing) begin
      mem_write_en = !reset;
    end else if (|grant) begin
      mem_write_en   = 1'b1;
      mem_write_addr = grant[1] ? wb_addr : wa_addr;
      mem_write_data = grant[1] ? wb_data : wa_data;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (cnt == LAST) state_nx = RUN;
      RUN:   if (flush_en)    state_nx = CLEAR;
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (clearing) begin
        cnt <= (cnt == LAST) ? '0
                             : cnt + ADDR_WIDTH'(1);
      end
    end
  end

  assign mem_read_en   = rd_en;
  assign mem_read_addr = rd_addr;

  // A read during clear always sees INIT_VALUE,
  // which also covers a collision with the
  // sweep write. In RUN only a same-address
  // granted write overrides the macro output.
  always_ff @(posedge clk) begin
    if (reset) begin
      byp      <= 1'b0;
      byp_data <= INIT_VALUE;
    end else if (rd_en) begin
      if (clearing) begin
        byp      <= 1'b1;
        byp_data <= INIT_VALUE;
      end else if (mem_write_en
                   && mem_write_addr == rd_addr) begin
        byp      <= 1'b1;
        byp_data <= mem_write_data;
      end else begin
        byp      <= 1'b0;
      end
    end
  end

  assign rd_data = byp ? byp_data : mem_read_data;

endmodule

// File: tb/tb_sram_1r1w_clear_arb.sv
// Self-checking bench for sram_1r1w_clear_arb.
// Reference: flat memory array + last-winner flag.
module tb_sram_1r1w_clear_arb;

  localparam int SZ = 52;
  localparam int DW = 20;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_en;
  logic          init_done;
  logic          wa_valid, wb_valid;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic          wa_ready, wb_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_en;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_data;

  int n_chk = 0;
  int n_err = 0;
  int oob   = 0;

  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] refmem [0:SZ-1];
  bit            last_b;

  always #5 clk = ~clk;

  sram_1r1w_clear_arb #(
    .DATA_WIDTH(DW),
    .SIZE      (SZ),
    .INIT_VALUE(20'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_en      (flush_en),
    .init_done     (init_done),
    .wa_valid      (wa_valid),
    .wa_addr       (wa_addr),
    .wa_data       (wa_data),
    .wa_ready      (wa_ready),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_ready      (wb_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .mem_write_en  (mem_write_en),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_en   (mem_read_en),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data)
  );

  // Macro model: read-before-write, no reset.
  always @(posedge clk) begin
    if (mem_read_en)
      mem_read_data <= mem[mem_read_addr];
    if (mem_write_en) begin
      if (int'(mem_write_addr) >= SZ) oob++;
      else mem[mem_write_addr] <= mem_write_data;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_en = 0;
    wa_valid = 0; wb_valid = 0;
    wa_addr  = 0; wb_addr  = 0;
    wa_data  = 0; wb_data  = 0;
    rd_en    = 0; rd_addr  = 0;
  endtask

  // Starts in clear cycle 0; A requests all along
  // and must never be accepted.
  task automatic check_sweep();
    for (int c = 0; c < SZ; c++) begin
      wa_valid = 1; wa_addr = 6'd1;
      wa_data  = 20'hFFFFF;
      flush_en = (c % 7 == 3);
      #1;
      check("clr_we", mem_write_en, 1);
      check("clr_addr", mem_write_addr, c);
      check("clr_data", mem_write_data, 0);
      check("clr_done", init_done, 0);
      check("clr_ardy", wa_ready, 0);
      tick();
    end
    idle();
    #1;
    check("done_rise", init_done, 1);
    check("run_we", mem_write_en, 0);
    for (int i = 0; i < SZ; i++) refmem[i] = 0;
  endtask

  task automatic run_cycle(
    input bit av, input logic [AW-1:0] aa,
    input logic [DW-1:0] ad,
    input bit bv, input logic [AW-1:0] ba,
    input logic [DW-1:0] bd,
    input bit rv, input logic [AW-1:0] ra,
    input bit fl,
    output bit ga, output bit gb);
    logic [DW-1:0] exp_rd;
    wa_valid = av; wa_addr = aa; wa_data = ad;
    wb_valid = bv; wb_addr = ba; wb_data = bd;
    rd_en = rv; rd_addr = ra; flush_en = fl;
    ga = av && (!bv || last_b);
    gb = bv && !ga;
    #1;
    check("run_done", init_done, 1);
    check("a_ready", wa_ready, ga);
    check("b_ready", wb_ready, gb);
    check("we", mem_write_en, ga || gb);
    if (ga) begin
      check("wa_addr", mem_write_addr, aa);
      check("wa_data", mem_write_data, ad);
      refmem[aa] = ad;
    end
    if (gb) begin
      check("wb_addr", mem_write_addr, ba);
      check("wb_data", mem_write_data, bd);
      refmem[ba] = bd;
    end
    if (ga || gb) last_b = gb;
    check("rd_en", mem_read_en, rv);
    exp_rd = refmem[ra];
    tick();
    idle();
    if (rv) check("rd_data", rd_data, exp_rd);
  endtask

  initial begin
    bit ga, gb;
    bit pav, pbv;
    logic [AW-1:0] paa, pba;
    logic [DW-1:0] pad, pbd;
    bit seq [4];
    for (int i = 0; i < 64; i++)
      mem[i] = DW'($urandom);
    idle();
    reset  = 1;
    last_b = 1;
    wa_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_done", init_done, 0);
      check("rst_ardy", wa_ready, 0);
      check("rst_we", mem_write_en, 0);
      tick();
    end
    reset = 0;
    check_sweep();

    for (int i = 0; i < 4; i++) begin
      run_cycle(1, 6'd20, DW'(i + 1),
                1, 6'd21, DW'(i + 16),
                0, 0, 0, ga, gb);
      seq[i] = gb;
    end
    check("alt_abab",
          {28'd0, seq[0], seq[1], seq[2], seq[3]},
          32'b0101);
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 0, 1, 6'd22, DW'(i + 40),
                0, 0, 0, ga, gb);
      check("b_alone", gb, 1);
    end

    run_cycle(1, 6'd5, 20'h12345, 0, 0, 0,
              0, 0, 0, ga, gb);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 6'd5, 0, ga, gb);
    check("rd5", rd_data, 20'h12345);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 6'd6, 0, ga, gb);
    check("rd6", rd_data, 0);

    run_cycle(1, 6'd9, 20'hABCDE, 0, 0, 0,
              1, 6'd9, 0, ga, gb);
    check("byp9", rd_data, 20'hABCDE);

    // Random traffic; requesters hold until ready.
    pav = 0; pbv = 0;
    paa = 0; pba = 0; pad = 0; pbd = 0;
    for (int n = 0; n < 300; n++) begin
      if (!pav && $urandom_range(1, 0) == 1) begin
        pav = 1;
        paa = AW'($urandom_range(SZ - 1, 0));
        pad = DW'($urandom);
      end
      if (!pbv && $urandom_range(1, 0) == 1) begin
        pbv = 1;
        pba = AW'($urandom_range(SZ - 1, 0));
        pbd = DW'($urandom);
      end
      run_cycle(pav, paa, pad, pbv, pba, pbd,
                $urandom_range(1, 0) == 1,
                AW'($urandom_range(SZ - 1, 0)),
                0, ga, gb);
      if (ga) pav = 0;
      if (gb) pbv = 0;
    end

    run_cycle(1, 6'd3, 20'h77777, 0, 0, 0,
              0, 0, 0, ga, gb);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
    for (int c = 0; c < SZ; c++) begin
      rd_en = (c == 0 || c == 10 || c == SZ - 1);
      rd_addr = (c == 0) ? 6'd3 : AW'(c);
      #1;
      check("fl_done", init_done, 0);
      check("fl_addr", mem_write_addr, c);
      tick();
      if (rd_en) check("fl_rd", rd_data, 0);
      idle();
    end
    #1;
    check("fl_rise", init_done, 1);
    for (int i = 0; i < SZ; i++) refmem[i] = 0;
    run_cycle(0, 0, 0, 0, 0, 0, 1, 6'd3, 0, ga, gb);
    check("rd3_post", rd_data, 0);

    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
    for (int c = 0; c < 20; c++) tick();
    #1;
    check("cnt20", mem_write_addr, 20);
    reset = 1;
    last_b = 1;
    wa_valid = 1;
    #1;
    check("mid_rst_we", mem_write_en, 0);
    check("mid_rst_rdy", wa_ready, 0);
    tick();
    reset = 0;
    check_sweep();
    run_cycle(1, 6'd7, 20'h00042, 1, 6'd8, 20'h1,
              1, 6'd7, 0, ga, gb);
    check("post_rst_a", ga, 1);

    check("oob_writes", oob, 0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
